// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with optional skid entry, flush and stall counter
module pipe_stage_reg #(
  parameter int DATA_W  = 160,
  parameter int CTRL_W  = 16,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              head_valid, skid_valid;
  logic [DATA_W-1:0] head_data, skid_data;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic              head_valid_n, skid_valid_n;
  logic [DATA_W-1:0] head_data_n, skid_data_n;
  logic [CTRL_W-1:0] head_ctrl_n, skid_ctrl_n;
  logic              push, pop;
  // with the skid entry, readiness comes from registered state only, cutting the out_ready path
  always_comb begin
    in_ready  = SKID_EN ? !skid_valid : (!head_valid || out_ready);
    push      = in_valid && in_ready;
    pop       = head_valid && out_ready;
    out_valid = head_valid;
    out_data  = head_data;
    out_ctrl  = head_valid ? head_ctrl : '0;
    occ       = {1'b0, head_valid} + {1'b0, skid_valid};
  end
  // next-state of head/skid; flush squashes ctrl and validity but keeps data
  always_comb begin
    head_valid_n = head_valid;
    head_data_n  = head_data;
    head_ctrl_n  = head_ctrl;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_ctrl_n  = skid_ctrl;
    if (flush) begin
      head_valid_n = 1'b0;
      skid_valid_n = 1'b0;
      head_ctrl_n  = '0;
      skid_ctrl_n  = '0;
    end else if (skid_valid && pop) begin
      head_data_n  = skid_data;
      head_ctrl_n  = skid_ctrl;
      skid_valid_n = 1'b0;
    end else if (push && (!head_valid || pop)) begin
      head_valid_n = 1'b1;
      head_data_n  = in_data;
      head_ctrl_n  = in_ctrl;
    end else if (push && SKID_EN) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
      skid_ctrl_n  = in_ctrl;
    end else if (pop) begin
      head_valid_n = 1'b0;
    end
  end
  // storage registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      head_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else begin
      head_valid <= head_valid_n;
      head_data  <= head_data_n;
      head_ctrl  <= head_ctrl_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_ctrl  <= skid_ctrl_n;
    end
  end
  // saturating count of stalled cycles; clear wins over increment, flush does not touch it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (cnt_clr) stall_cnt <= '0;
    else if (head_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule
